mdu_controller: RTL and testbench

MDU_CONTROLLER -- requirements
Module: mdu_controller

---
 rtl/mdu_controller.sv | 206 ++++++++++++++++++++
 tb/tb_mdu_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_controller.sv
// RV32/64 M-extension multiply/divide unit with valid/ready handshakes.
// Iterative shift-add multiply and restoring divide, ITER_BITS per cycle.
module mdu_controller #(
  parameter int WIDTH     = 32,
  parameter int ITER_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             illegal
);

  localparam int N  = WIDTH / ITER_BITS;
  localparam int CW = $clog2(N) + 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [W2-1:0]     acc;
  logic [W2-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic              qneg;
  logic              rneg;

  logic              is_m;
  logic              b_zero;
  logic              b_ones;
  logic              a_min;
  logic              fast_dz;
  logic              fast_ov;
  logic              fast;
  logic [WIDTH-1:0]  fast_res;

  logic              a_sgn_m;
  logic              b_neg_m;
  logic [W2-1:0]     a_ext;
  logic [W2-1:0]     mul_init;
  logic              d_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;

  logic [W2-1:0]     acc_m;
  logic [W2-1:0]     acc_d;
  logic [W2-1:0]     step_acc;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  final_res;

  assign is_m    = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign b_zero  = (SrcB == '0);
  assign b_ones  = (SrcB == '1);
  assign a_min   = (SrcA == {1'b1, {(WIDTH-1){1'b0}}});
  assign fast_dz = is_m && Funct3[2] && b_zero;
  assign fast_ov = is_m && Funct3[2] && !Funct3[0] && a_min && b_ones;
  assign fast    = !is_m || fast_dz || fast_ov;

  always_comb begin
    fast_res = '0;
    unique case (1'b1)
      fast_dz: fast_res = Funct3[1] ? SrcA : '1;
      fast_ov: fast_res = Funct3[1] ? '0 : SrcA;
      default: fast_res = '0;
    endcase
  end

  // Negative signed rs2 is folded in by pre-loading -(A << WIDTH).
  assign a_sgn_m  = (Funct3[1:0] != 2'b11);
  assign b_neg_m  = !Funct3[1] && SrcB[WIDTH-1];
  assign a_ext    = {{WIDTH{a_sgn_m && SrcA[WIDTH-1]}}, SrcA};
  assign mul_init = b_neg_m ? ({W2{1'b0}} - {SrcA, {WIDTH{1'b0}}})
                            : '0;

  assign d_sgn = !Funct3[0];
  assign a_neg = d_sgn && SrcA[WIDTH-1];
  assign b_neg = d_sgn && SrcB[WIDTH-1];
  assign a_mag = a_neg ? -SrcA : SrcA;
  assign b_mag = b_neg ? -SrcB : SrcB;

  function automatic logic [W2-1:0] div_step(
    input logic [W2-1:0]    a,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0] r;
    r = a[W2-1:WIDTH-1];
    if (r >= {1'b0, d}) begin
      r = r - {1'b0, d};
      div_step = {r[WIDTH-1:0], a[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {a[W2-2:0], 1'b0};
    end
  endfunction

  always_comb begin
    acc_m = acc;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (mplier[i]) acc_m = acc_m + (mcand << i);
    end
    acc_d = acc;
    for (int i = 0; i < ITER_BITS; i++) begin
      acc_d = div_step(acc_d, mplier);
    end
    step_acc = op[2] ? acc_d : acc_m;
  end

  assign quo = step_acc[WIDTH-1:0];
  assign rem = step_acc[W2-1:WIDTH];

  always_comb begin
    final_res = '0;
    case (op)
      3'b000: final_res = quo;
      3'b001: final_res = rem;
      3'b010: final_res = rem;
      3'b011: final_res = rem;
      3'b100: final_res = qneg ? -quo : quo;
      3'b101: final_res = quo;
      3'b110: final_res = rneg ? -rem : rem;
      3'b111: final_res = rem;
      default: final_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Result    <= '0;
      illegal   <= 1'b0;
      cnt       <= '0;
      op        <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (fast) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              Result    <= fast_res;
              illegal   <= !is_m;
            end else begin
              state <= CALC;
              cnt   <= CW'(N);
              op    <= Funct3;
              if (Funct3[2]) begin
                acc    <= {{WIDTH{1'b0}}, a_mag};
                mplier <= b_mag;
                qneg   <= a_neg ^ b_neg;
                rneg   <= a_neg;
              end else begin
                acc    <= mul_init;
                mcand  <= a_ext;
                mplier <= SrcB;
              end
            end
          end
        end
        CALC: begin
          acc   <= step_acc;
          mcand <= mcand << ITER_BITS;
          if (!op[2]) mplier <= mplier >> ITER_BITS;
          if (cnt != '0) cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            Result    <= final_res;
            illegal   <= 1'b0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_controller.sv
// Directed bench for mdu_controller: 32-bit/1-bit-per-cycle and
// 16-bit/2-bits-per-cycle instances.
module tb_mdu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        in_valid, in_ready, out_valid, out_ready, illegal;
  logic [1:0]  alu_op;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] src_a, src_b, result;

  logic        v16, rdy16, ov16, or16, ill16;
  logic [1:0]  op16;
  logic [6:0]  f7_16;
  logic [2:0]  f3_16;
  logic [15:0] a16, b16, res16;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mdu_controller #(.WIDTH(32), .ITER_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(alu_op), .Funct7(funct7), .Funct3(funct3),
    .SrcA(src_a), .SrcB(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(result), .illegal(illegal)
  );

  mdu_controller #(.WIDTH(16), .ITER_BITS(2)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16), .in_ready(rdy16),
    .ALUOp(op16), .Funct7(f7_16), .Funct3(f3_16),
    .SrcA(a16), .SrcB(b16),
    .out_valid(ov16), .out_ready(or16),
    .Result(res16), .illegal(ill16)
  );

  task automatic send(input logic [1:0] aop, input logic [6:0] f7,
                      input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_ready: in_ready=%0b want 1", in_ready);
    end
    alu_op = aop; funct7 = f7; funct3 = f3;
    src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a = 32'hDEADBEEF; src_b = 32'h0BADF00D; funct3 = ~f3;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++;
    if (result !== 32'h0) begin fails++; $display("FAIL rst_result: got %h want 0", result); end
    checks++;
    if (illegal !== 1'b0) begin fails++; $display("FAIL rst_illegal: got %0b want 0", illegal); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int cyc;
    send(2'b10, 7'h01, 3'b000, 32'd7, 32'hFFFFFFFD);
    wait_out(cyc);
    checks++;
    if (cyc != 33) begin fails++; $display("FAIL mul_lat: got %0d want 33", cyc); end
    checks++;
    if (result !== 32'hFFFFFFEB) begin fails++; $display("FAIL mul_res: got %h want ffffffeb", result); end
    checks++;
    if (illegal !== 1'b0) begin fails++; $display("FAIL mul_illegal: got %0b want 0", illegal); end
    drain();
  endtask

  task automatic test_mulh();
    int cyc;
    send(2'b10, 7'h01, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_out(cyc);
    checks++;
    if (result !== 32'hFFFFFFFE) begin fails++; $display("FAIL mulhu_res: got %h want fffffffe", result); end
    drain();
    send(2'b10, 7'h01, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_out(cyc);
    checks++;
    if (result !== 32'h0) begin fails++; $display("FAIL mulh_res: got %h want 0", result); end
    drain();
    send(2'b10, 7'h01, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_out(cyc);
    checks++;
    if (result !== 32'hFFFFFFFF) begin fails++; $display("FAIL mulhsu_res: got %h want ffffffff", result); end
    drain();
  endtask

  task automatic test_div();
    int cyc;
    send(2'b10, 7'h01, 3'b100, 32'hFFFFFFF9, 32'd2);
    wait_out(cyc);
    checks++;
    if (cyc != 33) begin fails++; $display("FAIL div_lat: got %0d want 33", cyc); end
    checks++;
    if (result !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_res: got %h want fffffffd", result); end
    drain();
    send(2'b10, 7'h01, 3'b110, 32'hFFFFFFF9, 32'd2);
    wait_out(cyc);
    checks++;
    if (result !== 32'hFFFFFFFF) begin fails++; $display("FAIL rem_res: got %h want ffffffff", result); end
    drain();
    send(2'b10, 7'h01, 3'b101, 32'd7, 32'd0);
    wait_out(cyc);
    checks++;
    if (cyc != 1) begin fails++; $display("FAIL divu0_lat: got %0d want 1", cyc); end
    checks++;
    if (result !== 32'hFFFFFFFF) begin fails++; $display("FAIL divu0_res: got %h want ffffffff", result); end
    drain();
    send(2'b10, 7'h01, 3'b111, 32'd5, 32'd0);
    wait_out(cyc);
    checks++;
    if (result !== 32'd5 || cyc != 1) begin fails++; $display("FAIL remu0: got %h cyc %0d want 5 cyc 1", result, cyc); end
    drain();
  endtask

  task automatic test_overflow();
    int cyc;
    send(2'b10, 7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF);
    wait_out(cyc);
    checks++;
    if (cyc != 1) begin fails++; $display("FAIL ovf_div_lat: got %0d want 1", cyc); end
    checks++;
    if (result !== 32'h80000000) begin fails++; $display("FAIL ovf_div_res: got %h want 80000000", result); end
    drain();
    send(2'b10, 7'h01, 3'b110, 32'h80000000, 32'hFFFFFFFF);
    wait_out(cyc);
    checks++;
    if (result !== 32'h0 || cyc != 1) begin fails++; $display("FAIL ovf_rem: got %h cyc %0d want 0 cyc 1", result, cyc); end
    drain();
  endtask

  task automatic test_illegal();
    int cyc;
    send(2'b10, 7'h00, 3'b000, 32'd9, 32'd4);
    wait_out(cyc);
    checks++;
    if (cyc != 1) begin fails++; $display("FAIL ill_lat: got %0d want 1", cyc); end
    checks++;
    if (illegal !== 1'b1 || result !== 32'h0) begin fails++; $display("FAIL ill_out: got ill %0b res %h want 1 0", illegal, result); end
    drain();
  endtask

  task automatic test_hold();
    int cyc;
    int bad = 0;
    send(2'b10, 7'h01, 3'b000, 32'd3, 32'd5);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (result !== 32'd15 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL hs_in_ready: got %0b want 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL hs_after: got ov %0b rdy %0b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_ignore();
    int cyc;
    send(2'b10, 7'h01, 3'b000, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    alu_op = 2'b00; funct7 = 7'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL ign_ov: got %0b want 0", out_valid); end
    wait_out(cyc);
    checks++;
    if (cyc != 28 || result !== 32'd42 || illegal !== 1'b0) begin
      fails++;
      $display("FAIL ign_res: got cyc %0d res %h ill %0b want 28 2a 0", cyc, result, illegal);
    end
    drain();
  endtask

  task automatic test_reset_calc();
    int seen = 0;
    send(2'b10, 7'h01, 3'b000, 32'd11, 32'd13);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      fails++;
      $display("FAIL rst_calc: got ov %0b rdy %0b res %h want 0 1 0", out_valid, in_ready, result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin fails++; $display("FAIL rst_ghost: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    send(2'b10, 7'h01, 3'b101, 32'd100, 32'd7);
    wait_out(cyc);
    checks++;
    if (result !== 32'd14 || cyc != 33) begin fails++; $display("FAIL b2b_divu: got %h cyc %0d want e cyc 33", result, cyc); end
    drain();
    send(2'b10, 7'h01, 3'b111, 32'd100, 32'd7);
    wait_out(cyc);
    checks++;
    if (result !== 32'd2) begin fails++; $display("FAIL b2b_remu: got %h want 2", result); end
    drain();
    send(2'b10, 7'h01, 3'b100, 32'd7, 32'hFFFFFFFE);
    wait_out(cyc);
    checks++;
    if (result !== 32'hFFFFFFFD) begin fails++; $display("FAIL b2b_div: got %h want fffffffd", result); end
    drain();
    send(2'b10, 7'h01, 3'b110, 32'd7, 32'hFFFFFFFE);
    wait_out(cyc);
    checks++;
    if (result !== 32'd1) begin fails++; $display("FAIL b2b_rem: got %h want 1", result); end
    drain();
  endtask

  task automatic test_w16();
    int cyc;
    for (int t = 0; t < 2; t++) begin
      checks++;
      if (rdy16 !== 1'b1) begin fails++; $display("FAIL w16_ready: got %0b want 1", rdy16); end
      op16 = 2'b10; f7_16 = 7'h01;
      f3_16 = (t == 0) ? 3'b000 : 3'b110;
      a16 = (t == 0) ? 16'd300 : 16'hFC18;
      b16 = (t == 0) ? 16'd300 : 16'd7;
      v16 = 1'b1;
      @(posedge clk); #1;
      v16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
      cyc = 1;
      while (!ov16 && cyc < 30) begin
        @(posedge clk); #1; cyc++;
      end
      checks++;
      if (cyc != 9) begin fails++; $display("FAIL w16_lat%0d: got %0d want 9", t, cyc); end
      checks++;
      if (t == 0 && res16 !== 16'h5F90) begin fails++; $display("FAIL w16_mul: got %h want 5f90", res16); end
      if (t == 1 && res16 !== 16'hFFFA) begin fails++; $display("FAIL w16_rem: got %h want fffa", res16); end
      or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct7 = 7'h00; funct3 = 3'b000;
    src_a = 32'h0; src_b = 32'h0;
    v16 = 1'b0; or16 = 1'b0;
    op16 = 2'b00; f7_16 = 7'h00; f3_16 = 3'b000;
    a16 = 16'h0; b16 = 16'h0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_overflow();
    test_illegal();
    test_hold();
    test_ignore();
    test_reset_calc();
    test_back_to_back();
    test_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
